// File: rtl/pipelined_segment_adder.sv
// pipelined_segment_adder
//   Pipelined adder/subtractor. A WIDTH-bit operation is split into N = WIDTH/SEG
//   carry-chained segments. Stage k resolves segment k and registers the carry
//   for stage k+1, so one segment is resolved per clock. Operations enter under
//   a valid/ready handshake. The whole pipe freezes while the consumer stalls.
//
// Parameters
//   WIDTH      operand/result width (multiple of SEG)
//   SEG        segment width; N = WIDTH/SEG stages, latency N cycles
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   in_valid   operation offered on a, b, cin, sub
//   in_ready   operation accepted this cycle (low while stalled or in reset)
//   a, b       operands
//   cin        carry-in (ignored when sub=1)
//   sub        0: a+b+cin, 1: a-b
//   out_valid  result present on sum/cout/ovf/zero
//   out_ready  consumer takes the result this cycle
//   sum        result modulo 2^WIDTH
//   cout       carry out of MSB (sub: 1 = no borrow)
//   ovf        signed two's-complement overflow
//   zero       sum == 0
module pipelined_segment_adder #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int N = WIDTH / SEG;

  // Per-stage state. B is inverted on entry for subtraction, so the stages
  // themselves never need the mode bit: every stage is a plain adder.
  // a_rem/b_rem hold the not-yet-consumed operand segments shifted down, so
  // every stage consumes the low SEG bits of what it receives.
  logic             valid_reg [N];
  logic             carry_reg [N];
  logic [WIDTH-1:0] acc_reg   [N];
  logic [WIDTH-1:0] a_rem_reg [N];
  logic [WIDTH-1:0] b_rem_reg [N];
  logic             ovf_reg;
  logic             zero_reg;

  logic stall;

  // Whole-pipe freeze: bubbles are not squeezed out while the consumer stalls.
  assign stall    = valid_reg[N-1] & ~out_ready;
  assign in_ready = ~reset & ~stall;

  assign out_valid = valid_reg[N-1];
  assign sum       = acc_reg[N-1];
  assign cout      = carry_reg[N-1];
  assign ovf       = ovf_reg;
  assign zero      = zero_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_stage
      logic             v_in;
      logic             c_in;
      logic [WIDTH-1:0] acc_in;
      logic [WIDTH-1:0] a_in;
      logic [WIDTH-1:0] b_in;
      logic [SEG:0]     seg_sum;
      logic [WIDTH-1:0] acc_next;

      if (gi == 0) begin : g_head
        assign v_in   = in_valid & in_ready;
        // Subtraction is a + ~b + 1, so the +1 rides on the stage-0 carry.
        assign c_in   = sub | cin;
        assign acc_in = '0;
        assign a_in   = a;
        assign b_in   = sub ? ~b : b;
      end else begin : g_body
        assign v_in   = valid_reg[gi-1];
        assign c_in   = carry_reg[gi-1];
        assign acc_in = acc_reg[gi-1];
        assign a_in   = a_rem_reg[gi-1];
        assign b_in   = b_rem_reg[gi-1];
      end

      assign seg_sum = {1'b0, a_in[SEG-1:0]} + {1'b0, b_in[SEG-1:0]} + {{SEG{1'b0}}, c_in};

      always_comb begin
        acc_next = acc_in;
        acc_next[gi*SEG +: SEG] = seg_sum[SEG-1:0];
      end

      // Data only moves with a valid token, so the outputs keep their last
      // result while bubbles pass through the final stage.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          valid_reg[gi] <= 1'b0;
          carry_reg[gi] <= 1'b0;
          acc_reg[gi]   <= '0;
          a_rem_reg[gi] <= '0;
          b_rem_reg[gi] <= '0;
        end else if (!stall) begin
          valid_reg[gi] <= v_in;
          if (v_in) begin
            carry_reg[gi] <= seg_sum[SEG];
            acc_reg[gi]   <= acc_next;
            a_rem_reg[gi] <= a_in >> SEG;
            b_rem_reg[gi] <= b_in >> SEG;
          end
        end
      end

      if (gi == N - 1) begin : g_tail
        // The top segment carries the operand sign bits, so overflow and zero
        // are resolved here together with the final segment.
        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            ovf_reg  <= 1'b0;
            zero_reg <= 1'b0;
          end else if (!stall && v_in) begin
            ovf_reg  <= (a_in[SEG-1] == b_in[SEG-1]) & (seg_sum[SEG-1] != a_in[SEG-1]);
            zero_reg <= ~|acc_next;
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_pipelined_segment_adder.sv
module tb_pipelined_segment_adder;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  logic        clk;
  logic        reset;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        sub;

  // Three instances: 32/8 (N=4), 16/4 (N=4), 8/8 (N=1).
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic        cout      [3];
  logic        ovf       [3];
  logic        zero      [3];
  logic [31:0] s0;
  logic [15:0] s1;
  logic [7:0]  s2;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   n_out  [3];
  res_t exp_q  [3][$];

  pipelined_segment_adder #(.WIDTH(32), .SEG(8)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .sum(s0), .cout(cout[0]), .ovf(ovf[0]), .zero(zero[0])
  );

  pipelined_segment_adder #(.WIDTH(16), .SEG(4)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a[15:0]), .b(b[15:0]), .cin(cin), .sub(sub), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .sum(s1), .cout(cout[1]), .ovf(ovf[1]), .zero(zero[1])
  );

  pipelined_segment_adder #(.WIDTH(8), .SEG(8)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a[7:0]), .b(b[7:0]), .cin(cin), .sub(sub), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .sum(s2), .cout(cout[2]), .ovf(ovf[2]), .zero(zero[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int width_of(input int d);
    return (d == 0) ? 32 : (d == 1) ? 16 : 8;
  endfunction

  function automatic int n_of(input int d);
    return (d == 2) ? 1 : 4;
  endfunction

  function automatic logic [31:0] got_sum(input int d);
    case (d)
      0:       return s0;
      1:       return {16'h0, s1};
      default: return {24'h0, s2};
    endcase
  endfunction

  // Reference: whole-word arithmetic on a (w+1)-bit quantity.
  function automatic res_t model(input logic [31:0] va, input logic [31:0] vb,
                                 input logic vc, input logic vs, input int w);
    logic [32:0] mask, fa, fb, full;
    res_t r;
    mask   = (33'd1 << w) - 33'd1;
    fa     = {1'b0, va} & mask;
    fb     = (vs ? ~{1'b0, vb} : {1'b0, vb}) & mask;
    full   = fa + fb + (vs ? 33'd1 : {32'd0, vc});
    r.sum  = full[31:0] & mask[31:0];
    r.cout = full[w];
    r.ovf  = (fa[w-1] == fb[w-1]) && (full[w-1] != fa[w-1]);
    r.zero = (r.sum == 32'd0);
    return r;
  endfunction

  // Scoreboard: push on accepted input, pop and compare on output transfer.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (in_valid[d] && in_ready[d])
        exp_q[d].push_back(model(a, b, cin, sub, width_of(d)));
      if (out_valid[d] && out_ready[d]) begin
        n_out[d] = n_out[d] + 1;
        checks = checks + 1;
        if (exp_q[d].size() == 0) begin
          errors = errors + 1;
          $display("FAIL sb_unexpected dut%0d: got sum=%h with no pending operation", d, got_sum(d));
        end else begin
          res_t e;
          e = exp_q[d].pop_front();
          if (got_sum(d) !== e.sum || cout[d] !== e.cout || ovf[d] !== e.ovf || zero[d] !== e.zero) begin
            errors = errors + 1;
            $display("FAIL sb_result dut%0d: got sum=%h c=%b v=%b z=%b, expected sum=%h c=%b v=%b z=%b",
                     d, got_sum(d), cout[d], ovf[d], zero[d], e.sum, e.cout, e.ovf, e.zero);
          end else begin
            $display("dut%0d out sum=%h c=%b v=%b z=%b ok", d, got_sum(d), cout[d], ovf[d], zero[d]);
          end
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_op(input int d, input logic [31:0] va, input logic [31:0] vb,
                         input logic vc, input logic vs);
    int w;
    a = va; b = vb; cin = vc; sub = vs;
    in_valid[d] = 1'b1;
    w = 0;
    @(negedge clk);
    while (!in_ready[d] && w < 50) begin
      @(negedge clk);
      w++;
    end
    checks = checks + 1;
    if (w >= 50) begin
      errors = errors + 1;
      $display("FAIL send_timeout dut%0d: in_ready=%b, required 1 within 50 cycles", d, in_ready[d]);
    end
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
  endtask

  task automatic drain(input int d);
    int w;
    w = 0;
    while (exp_q[d].size() != 0 && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    checks = checks + 1;
    if (exp_q[d].size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain_timeout dut%0d: %0d results pending, required 0", d, exp_q[d].size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    for (int d = 0; d < 3; d++) begin
      checks = checks + 2;
      if (in_ready[d] !== 1'b0) begin
        errors = errors + 1;
        $display("FAIL reset_in_ready_held dut%0d: got %b, required 0", d, in_ready[d]);
      end
      if (out_valid[d] !== 1'b0) begin
        errors = errors + 1;
        $display("FAIL reset_out_valid dut%0d: got %b, required 0", d, out_valid[d]);
      end
    end
    repeat (2) @(posedge clk);
    #1;
    checks = checks + 1;
    if (s0 !== 32'h0 || cout[0] !== 1'b0 || ovf[0] !== 1'b0 || zero[0] !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL reset_outputs: got sum=%h c=%b v=%b z=%b, required all 0", s0, cout[0], ovf[0], zero[0]);
    end
    reset = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      checks = checks + 1;
      if (in_ready[d] !== 1'b1) begin
        errors = errors + 1;
        $display("FAIL reset_in_ready_release dut%0d: got %b, required 1", d, in_ready[d]);
      end
    end
    $display("reset test done");
    @(posedge clk); #1;
  endtask

  task automatic test_directed(input int d, input logic [31:0] va, input logic [31:0] vb,
                               input logic vc, input logic vs, input logic [31:0] xs,
                               input logic xc, input logic xv, input logic xz, input string name);
    int lat;
    a = va; b = vb; cin = vc; sub = vs;
    in_valid[d] = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i == 1) in_valid[d] = 1'b0;
      if (out_valid[d]) begin
        lat = i;
        break;
      end
    end
    checks = checks + 2;
    if (lat != n_of(d)) begin
      errors = errors + 1;
      $display("FAIL %s_latency dut%0d: got %0d cycles, required %0d", name, d, lat, n_of(d));
    end
    if (got_sum(d) !== xs || cout[d] !== xc || ovf[d] !== xv || zero[d] !== xz) begin
      errors = errors + 1;
      $display("FAIL %s_result dut%0d: got sum=%h c=%b v=%b z=%b, required sum=%h c=%b v=%b z=%b",
               name, d, got_sum(d), cout[d], ovf[d], zero[d], xs, xc, xv, xz);
    end
    $display("%s dut%0d a=%h b=%h cin=%b sub=%b -> sum=%h lat=%0d", name, d, va, vb, vc, vs, got_sum(d), lat);
    drain(d);
  endtask

  task automatic test_stream(input int d, input int count);
    int c0, w, base_out;
    base_out = n_out[d];
    c0 = cyc;
    fork
      begin
        for (int k = 0; k < count; k++)
          send_op(d, $urandom, $urandom, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
      end
      begin
        w = 0;
        @(negedge clk);
        while (!out_valid[d] && w < 50) begin
          @(negedge clk);
          w++;
        end
        checks = checks + 1;
        if (cyc - c0 != n_of(d)) begin
          errors = errors + 1;
          $display("FAIL stream_latency dut%0d: got %0d cycles, required %0d", d, cyc - c0, n_of(d));
        end
        for (int k = 1; k < count; k++) begin
          @(negedge clk);
          checks = checks + 1;
          if (out_valid[d] !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL stream_gap dut%0d: out_valid=%b at result %0d, required 1", d, out_valid[d], k);
          end
        end
      end
    join
    drain(d);
    checks = checks + 1;
    if (n_out[d] - base_out != count) begin
      errors = errors + 1;
      $display("FAIL stream_count dut%0d: got %0d results, required %0d", d, n_out[d] - base_out, count);
    end
    $display("stream dut%0d: %0d operations", d, count);
  endtask

  task automatic test_backpressure(input int d);
    int w, base_out;
    res_t snap;
    base_out = n_out[d];
    fork
      begin
        for (int k = 0; k < 6; k++)
          send_op(d, $urandom, $urandom, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
      end
      begin
        w = 0;
        @(negedge clk);
        while (!out_valid[d] && w < 50) begin
          @(negedge clk);
          w++;
        end
        @(posedge clk); #1;
        out_ready[d] = 1'b0;
        checks = checks + 1;
        if (out_valid[d] !== 1'b1) begin
          errors = errors + 1;
          $display("FAIL bp_valid dut%0d: got %b, required 1 at stall start", d, out_valid[d]);
        end
        snap = '{got_sum(d), cout[d], ovf[d], zero[d]};
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          checks = checks + 1;
          if (in_ready[d] !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL bp_in_ready dut%0d: got %b, required 0 during stall", d, in_ready[d]);
          end
          @(posedge clk); #1;
          checks = checks + 1;
          if (got_sum(d) !== snap.sum || cout[d] !== snap.cout || ovf[d] !== snap.ovf ||
              zero[d] !== snap.zero || out_valid[d] !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL bp_hold dut%0d: got sum=%h c=%b v=%b z=%b ov=%b, required sum=%h c=%b v=%b z=%b ov=1",
                     d, got_sum(d), cout[d], ovf[d], zero[d], out_valid[d], snap.sum, snap.cout, snap.ovf, snap.zero);
          end
        end
        out_ready[d] = 1'b1;
      end
    join
    drain(d);
    checks = checks + 1;
    if (n_out[d] - base_out != 6) begin
      errors = errors + 1;
      $display("FAIL bp_count dut%0d: got %0d results, required 6", d, n_out[d] - base_out);
    end
    $display("backpressure dut%0d done", d);
  endtask

  task automatic test_reset_midflight(input int d);
    for (int k = 0; k < 3; k++)
      send_op(d, $urandom, $urandom, 1'b0, 1'b0);
    @(posedge clk); #1;
    checks = checks + 1;
    if (out_valid[d] !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL rst_pre_valid dut%0d: got %b, required 1 before reset", d, out_valid[d]);
    end
    #2;
    reset = 1'b1;
    #1;
    checks = checks + 2;
    if (out_valid[d] !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL rst_out_valid dut%0d: got %b, required 0 right after reset", d, out_valid[d]);
    end
    if (in_ready[d] !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL rst_in_ready dut%0d: got %b, required 0 in reset", d, in_ready[d]);
    end
    for (int dd = 0; dd < 3; dd++) exp_q[dd].delete();
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks = checks + 1;
      if (out_valid[d] !== 1'b0) begin
        errors = errors + 1;
        $display("FAIL rst_stale dut%0d: out_valid=%b after reset, required 0", d, out_valid[d]);
      end
    end
    @(posedge clk); #1;
    $display("reset mid-flight dut%0d: pipe flushed", d);
    test_directed(d, 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0, 1'b0, "after_reset");
  endtask

  initial begin
    reset = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    for (int d = 0; d < 3; d++) begin
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b1;
      n_out[d]     = 0;
    end

    test_reset();
    test_directed(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, "ripple");
    test_directed(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, "ovf_add");
    test_directed(0, 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, "sub_borrow");
    test_directed(0, 32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0, 1'b0, "sub_cin_ignored");
    test_directed(0, 32'h0000_0007, 32'h0000_0007, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, "sub_zero");
    test_directed(0, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, "ovf_sub");
    test_stream(0, 16);
    test_backpressure(0);
    test_reset_midflight(0);
    test_directed(1, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, "ripple16");
    test_stream(1, 16);
    test_directed(2, 32'h0000_00FF, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0001, 1'b1, 1'b0, 1'b0, "ripple8");
    test_directed(2, 32'h0000_007F, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0080, 1'b0, 1'b1, 1'b0, "ovf8");
    test_stream(2, 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
